// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Definitions shared by the intersection traffic light controller and its
// pedestrian-side companion (ped_request_unit).
//   ped_state_t     : pedestrian FSM states (IDLE, REQ, WALK, CLEAR)
//   LAMP_ON/OFF     : kerbside lamp drive levels
//   T_WALK_DEFAULT  : default walk length agreed with the controller
// ---------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WALK  = 2'd2,
        CLEAR = 2'd3
    } ped_state_t;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;

    localparam int T_WALK_DEFAULT   = 8;
    localparam int T_CLEAR_DEFAULT  = 6;
    localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Brings the asynchronous push-button into the clock domain with a 2-flop
// synchronizer, then accepts a level change only after DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with the current stable level.
// A one-cycle registered pulse is produced on each accepted rising edge;
// accepted releases produce nothing.
// Ports:
//   clk      in  : clock
//   rst      in  : synchronous active-high reset
//   btn_raw  in  : asynchronous button, active-high
//   press    out : 1-cycle pulse on a debounced rising edge
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] stable_cnt;

    // The counter tracks how many samples in a row differed from the stable
    // level; any agreeing sample restarts it, so bounces never accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            stable     <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b != stable) begin
                if (stable_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable     <= sync_b;
                    press      <= sync_b;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ped_request_unit.sv
// ---------------------------------------------------------------------------
// ped_request_unit
// Pedestrian-side companion to the traffic light controller. Debounces the
// kerbside button, raises and holds ped_req until the controller grants
// ped_walk, and drives the WAIT / WALK / flashing DON'T-WALK lamps.
// A request made while walking or clearing is queued and re-issued after the
// clearance interval. A request left ungranted for T_REQ_MAX cycles sets a
// sticky fault flag.
// Optional feature: define PED_COUNTDOWN_EN to build the walk countdown;
// otherwise countdown is tied to 0.
// Ports:
//   clk            in  : clock
//   rst            in  : synchronous active-high reset
//   btn_raw        in  : asynchronous push-button
//   ped_walk       in  : walk grant from the controller
//   ped_req        out : request level to the controller
//   wait_lamp      out : request registered, awaiting grant
//   walk_lamp      out : WALK indication
//   dont_walk_lamp out : DON'T-WALK, steady or flashing during clearance
//   countdown      out : remaining expected walk cycles
//   fault          out : sticky grant-timeout flag
// ---------------------------------------------------------------------------
module ped_request_unit
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int T_WALK_EXP      = T_WALK_DEFAULT,
    parameter int T_CLEAR         = T_CLEAR_DEFAULT,
    parameter int FLASH_HALF      = 2,
    parameter int T_REQ_MAX       = 64,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             ped_walk,
    output logic             ped_req,
    output logic             wait_lamp,
    output logic             walk_lamp,
    output logic             dont_walk_lamp,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    logic             press;
    ped_state_t       state;
    logic             queued;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] clr_cnt;
    logic [CNT_W-1:0] flash_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .press   (press)
    );

    // Lamp outputs are written alongside each state change so they always
    // describe the state being entered. A grant overrides every other
    // transition; a press arriving with a fresh grant is dropped, while a
    // press during an ongoing walk or clearance is remembered in queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            queued         <= 1'b0;
            req_cnt        <= '0;
            clr_cnt        <= '0;
            flash_cnt      <= '0;
            ped_req        <= 1'b0;
            wait_lamp      <= LAMP_OFF;
            walk_lamp      <= LAMP_OFF;
            dont_walk_lamp <= LAMP_ON;
            fault          <= 1'b0;
        end else if (ped_walk) begin
            state          <= WALK;
            ped_req        <= 1'b0;
            wait_lamp      <= LAMP_OFF;
            walk_lamp      <= LAMP_ON;
            dont_walk_lamp <= LAMP_OFF;
            if (state == WALK && press) begin
                queued <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state     <= REQ;
                        queued    <= 1'b0;
                        req_cnt   <= '0;
                        ped_req   <= 1'b1;
                        wait_lamp <= LAMP_ON;
                    end
                end
                REQ: begin
                    if (req_cnt != '1) begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                    if (req_cnt >= CNT_W'(T_REQ_MAX - 1)) begin
                        fault <= 1'b1;
                    end
                end
                WALK: begin
                    state          <= CLEAR;
                    clr_cnt        <= '0;
                    flash_cnt      <= '0;
                    walk_lamp      <= LAMP_OFF;
                    dont_walk_lamp <= LAMP_ON;
                    if (press) begin
                        queued <= 1'b1;
                    end
                end
                CLEAR: begin
                    // A press on the final clearance cycle still counts as
                    // queued, so it is folded into the exit decision.
                    if (clr_cnt >= CNT_W'(T_CLEAR - 1)) begin
                        dont_walk_lamp <= LAMP_ON;
                        if (queued || press) begin
                            state     <= REQ;
                            queued    <= 1'b0;
                            req_cnt   <= '0;
                            ped_req   <= 1'b1;
                            wait_lamp <= LAMP_ON;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (press) begin
                            queued <= 1'b1;
                        end
                        if (flash_cnt >= CNT_W'(FLASH_HALF - 1)) begin
                            flash_cnt      <= '0;
                            dont_walk_lamp <= ~dont_walk_lamp;
                        end else begin
                            flash_cnt <= flash_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PED_COUNTDOWN_EN
    // Preloads on every entry into WALK (including re-grants during
    // clearance), then counts down and rests at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            countdown <= '0;
        end else if (ped_walk) begin
            if (state != WALK) begin
                countdown <= CNT_W'(T_WALK_EXP - 1);
            end else if (countdown != '0) begin
                countdown <= countdown - 1'b1;
            end
        end else begin
            countdown <= '0;
        end
    end
`else
    assign countdown = '0;
`endif

endmodule
